// File: rtl/randn_pkg.sv
// ============================================================================
//  Module  : randn_pkg
//  Brief   : Shared widths and gain format for the CLT Gaussian generator.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package randn_pkg;

    localparam int IN_W       = 8;
    localparam int N_LOG2     = 4;
    localparam int OUT_W      = 12;
    localparam int GAIN_W     = 8;
    localparam int GAIN_FRAC  = 7;
    localparam int UNITY_GAIN = 128;

endpackage : randn_pkg

`default_nettype wire

// File: rtl/randn_sat.sv
// ============================================================================
//  Module  : randn_sat
//  Brief   : Combinational signed clip to OUT_W bits with clip flag.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module randn_sat #(
    parameter int DIN_W = 21,
    parameter int OUT_W = 12
) (
    input  logic signed [DIN_W-1:0] i_data,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_sat
);

    generate
        if (DIN_W > OUT_W) begin : g_clip
            // Value fits only when all bits from the output sign bit upward agree.
            logic [DIN_W-OUT_W:0] w_top;
            logic                 w_ovf;

            assign w_top = i_data[DIN_W-1:OUT_W-1];
            assign w_ovf = !((&w_top) || !(|w_top));

            always_comb begin
                o_sat  = w_ovf;
                o_data = i_data[OUT_W-1:0];
                if (w_ovf) begin
                    o_data = {i_data[DIN_W-1], {(OUT_W-1){~i_data[DIN_W-1]}}};
                end
            end
        end else begin : g_pass
            assign o_data = OUT_W'(i_data);
            assign o_sat  = 1'b0;
        end
    endgenerate

endmodule : randn_sat

`default_nettype wire

// File: rtl/randn_clt.sv
// ============================================================================
//  Module  : randn_clt
//  Brief   : Sums 2^N_LOG2 centred uniform samples, scales by gain, saturates.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module randn_clt #(
    parameter int IN_W   = randn_pkg::IN_W,
    parameter int N_LOG2 = randn_pkg::N_LOG2,
    parameter int OUT_W  = randn_pkg::OUT_W
) (
    input  logic                          clk,
    input  logic                          RESET,
    input  logic [IN_W-1:0]               in_data,
    input  logic                          in_valid,
    input  logic [randn_pkg::GAIN_W-1:0]  gain,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          out_valid,
    output logic                          out_sat
);

    import randn_pkg::*;

    localparam int SUM_W  = IN_W + N_LOG2;
    localparam int PROD_W = SUM_W + GAIN_W + 1;

    logic signed [IN_W-1:0]   w_centred;
    logic signed [SUM_W-1:0]  w_acc_next;
    logic signed [GAIN_W:0]   w_gain_s;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_scaled;
    logic signed [OUT_W-1:0]  w_sat_data;
    logic                     w_sat;

    logic signed [SUM_W-1:0]  r_acc;
    logic [N_LOG2-1:0]        r_cnt;
    logic signed [SUM_W-1:0]  r_s1_sum;
    logic [GAIN_W-1:0]        r_s1_gain;
    logic                     r_s1_vld;
    logic signed [PROD_W-1:0] r_s2_val;
    logic                     r_s2_vld;

    // Offset-binary to two's complement is just an MSB flip.
    assign w_centred  = {~in_data[IN_W-1], in_data[IN_W-2:0]};
    assign w_acc_next = r_acc + SUM_W'(w_centred);

    assign w_gain_s = {1'b0, r_s1_gain};
    assign w_prod   = PROD_W'(r_s1_sum) * PROD_W'(w_gain_s);
    assign w_scaled = w_prod >>> GAIN_FRAC;

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_s1_sum  <= '0;
            r_s1_gain <= '0;
            r_s1_vld  <= 1'b0;
        end else begin
            r_s1_vld <= 1'b0;
            if (in_valid) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == {N_LOG2{1'b1}}) begin
                    // Block complete: hand off the sum and restart with no gap.
                    r_s1_sum  <= w_acc_next;
                    r_s1_gain <= gain;
                    r_s1_vld  <= 1'b1;
                    r_acc     <= '0;
                end else begin
                    r_acc <= w_acc_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_s2_val <= '0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_val <= w_scaled;
            end
        end
    end

    randn_sat #(
        .DIN_W (PROD_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .i_data (r_s2_val),
        .o_data (w_sat_data),
        .o_sat  (w_sat)
    );

    always_ff @(posedge clk) begin
        if (RESET) begin
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_s2_vld;
            if (r_s2_vld) begin
                out_data <= w_sat_data;
                out_sat  <= w_sat;
            end
        end
    end

endmodule : randn_clt

`default_nettype wire

// File: tb/tb_randn_clt.sv
// ============================================================================
//  Module  : tb_randn_clt
//  Brief   : Directed self-checking bench for randn_clt.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_randn_clt;

    logic              clk = 1'b0;
    logic              RESET;
    logic [7:0]        in_data;
    logic              in_valid;
    logic [7:0]        gain;
    logic signed [11:0] out_data;
    logic              out_valid;
    logic              out_sat;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int pulse_cnt = 0;
    int p_data [0:63];
    int p_sat  [0:63];
    int p_cyc  [0:63];
    int base;

    randn_clt u_dut (
        .clk       (clk),
        .RESET     (RESET),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .gain      (gain),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled 1 ns after each rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (out_valid === 1'b1 && pulse_cnt < 64) begin
            p_data[pulse_cnt] = int'(out_data);
            p_sat[pulse_cnt]  = int'(out_sat);
            p_cyc[pulse_cnt]  = cyc;
            pulse_cnt = pulse_cnt + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_block(input logic [7:0] val, input int count, input bit gaps);
        for (int i = 0; i < count; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(5, 0);
                for (int k = 0; k < g; k++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = 8'($urandom_range(255, 0));
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = val;
            @(posedge clk);
            #1;
            acc_cyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int target);
        int guard;
        guard = 0;
        while (pulse_cnt < target && guard < 40) begin
            @(posedge clk);
            guard++;
        end
        #2;
    endtask

    initial begin
        RESET    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        gain     = 8'd128;
        repeat (3) @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_sat", int'(out_sat), 0);
        RESET = 1'b0;

        // Mid-scale input gives a zero sum.
        send_block(8'd128, 16, 1'b0);
        wait_pulses(1);
        check("mid_pulses", pulse_cnt, 1);
        check("mid_latency", p_cyc[0] - acc_cyc, 2);
        check("mid_data", p_data[0], 0);
        check("mid_sat", p_sat[0], 0);

        send_block(8'd255, 16, 1'b0);
        wait_pulses(2);
        check("max_unity_data", p_data[1], 2032);
        check("max_unity_sat", p_sat[1], 0);

        gain = 8'd255;
        send_block(8'd255, 16, 1'b0);
        wait_pulses(3);
        check("max_gain_data", p_data[2], 2047);
        check("max_gain_sat", p_sat[2], 1);

        send_block(8'd0, 16, 1'b0);
        wait_pulses(4);
        check("min_gain_data", p_data[3], -2048);
        check("min_gain_sat", p_sat[3], 1);

        // Gapped input: only valid samples count.
        gain = 8'd128;
        send_block(8'd130, 16, 1'b1);
        wait_pulses(5);
        repeat (6) @(negedge clk);
        check("gap_pulses", pulse_cnt, 5);
        check("gap_data", p_data[4], 32);
        check("gap_latency", p_cyc[4] - acc_cyc, 2);
        check("hold_data", int'(out_data), 32);
        check("hold_sat", int'(out_sat), 0);

        // Partial block discarded by reset; in_valid during reset ignored.
        send_block(8'd200, 7, 1'b0);
        RESET    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd200;
        @(negedge clk);
        RESET    = 1'b0;
        in_valid = 1'b0;
        check("partial_no_pulse", pulse_cnt, 5);
        send_block(8'd129, 16, 1'b0);
        wait_pulses(6);
        check("after_reset_pulses", pulse_cnt, 6);
        check("after_reset_data", p_data[5], 16);

        // Reset with a result in flight cancels it.
        send_block(8'd136, 16, 1'b0);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        repeat (6) @(negedge clk);
        check("cancel_no_pulse", pulse_cnt, 6);
        check("cancel_out_data", int'(out_data), 0);

        // Back-to-back blocks, gain change mid second block.
        base = pulse_cnt;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = (i < 16) ? 8'd136 : 8'd120;
            if (i == 19) gain = 8'd64;
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_pulses(base + 2);
        repeat (4) @(negedge clk);
        check("b2b_pulses", pulse_cnt - base, 2);
        check("b2b_first", p_data[base], 128);
        check("b2b_second", p_data[base + 1], -64);
        check("b2b_spacing", p_cyc[base + 1] - p_cyc[base], 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_randn_clt

`default_nettype wire
